// File: rtl/dac_spi_driver.sv
// dac_spi_driver: serial DAC output stage for the reference-sine generators.
// Captures a 16-bit sample per strobe and shifts {CMD_WORD, data} out as a
// 24-bit SPI frame (SCLK idles high, DAC samples on SCLK falling edge).
// A 1-deep pending buffer absorbs strobes that arrive mid-frame.
//
// Ports:
//   clock, reset    rising-edge clock, synchronous active-high reset
//   readyToOutput   output enable; low drops strobes, pending and overrun
//   sampleStrobe    single-cycle strobe, dataIn valid in that cycle
//   dataIn[15:0]    sample to transmit
//   busy            frame pending, shifting or in the CS gap
//   frameDone       one-cycle pulse when dacCs_n returns high
//   overrun         sticky: a pending sample was overwritten
//   dacCs_n         DAC chip select, active low
//   dacSclk         DAC serial clock
//   dacSdi          DAC serial data, MSB first
//
// Optional feature macro: DAC_OFFSET_BINARY_EN
//   defined: bit 15 of captured data is inverted (two's complement to
//   offset binary) and a midscale frame (16'h8000) is sent after reset.
module dac_spi_driver #(
   parameter int unsigned CLK_DIV  = 4,
   parameter logic [7:0]  CMD_WORD = 8'h30,
   parameter int unsigned CS_GAP   = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        readyToOutput,
   input  logic        sampleStrobe,
   input  logic [15:0] dataIn,
   output logic        busy,
   output logic        frameDone,
   output logic        overrun,
   output logic        dacCs_n,
   output logic        dacSclk,
   output logic        dacSdi
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      GAP
   } state_t;

   localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_M1 = 16'(CS_GAP - 1);

`ifdef DAC_OFFSET_BINARY_EN
   localparam logic [15:0] FLIP = 16'h8000;
   localparam logic        PARK = 1'b1;
`else
   localparam logic [15:0] FLIP = 16'h0000;
   localparam logic        PARK = 1'b0;
`endif

   state_t      state_q;
   logic [23:0] sr_q;
   logic [15:0] cnt_q;
   logic [15:0] gcnt_q;
   logic [4:0]  bit_q;
   logic [15:0] pend_q;
   logic        pendV_q;
   logic        park_q;
   logic        busy_q;
   logic        done_q;
   logic        ovr_q;
   logic        cs_q;
   logic        sclk_q;
   logic        sdi_q;

   logic        accept_d;
   logic [15:0] sample_d;

   assign accept_d = sampleStrobe & readyToOutput;
   assign sample_d = dataIn ^ FLIP;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         gcnt_q  <= '0;
         bit_q   <= '0;
         pend_q  <= '0;
         pendV_q <= 1'b0;
         park_q  <= PARK;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
         cs_q    <= 1'b1;
         sclk_q  <= 1'b1;
         sdi_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // Lags the state by one cycle so busy covers the final IDLE edge,
         // while the strobe term raises it right after acceptance.
         busy_q <= accept_d | (state_q != IDLE) | pendV_q | park_q;

         // Strobes outside IDLE land in the pending buffer.
         if (!readyToOutput) begin
            pendV_q <= 1'b0;
            ovr_q   <= 1'b0;
         end else if (accept_d && state_q != IDLE) begin
            pend_q  <= sample_d;
            pendV_q <= 1'b1;
            if (pendV_q) ovr_q <= 1'b1;
         end

         unique case (state_q)
            IDLE: begin
               if (park_q) begin
                  sr_q    <= {CMD_WORD, 16'h8000};
                  park_q  <= 1'b0;
                  state_q <= LOAD;
                  if (accept_d) begin
                     pend_q  <= sample_d;
                     pendV_q <= 1'b1;
                  end
               end else if (pendV_q && readyToOutput) begin
                  // Send the older sample; a same-cycle strobe refills.
                  sr_q    <= {CMD_WORD, pend_q};
                  state_q <= LOAD;
                  if (accept_d) pend_q <= sample_d;
                  else          pendV_q <= 1'b0;
               end else if (accept_d) begin
                  sr_q    <= {CMD_WORD, sample_d};
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               cs_q    <= 1'b0;
               sclk_q  <= 1'b1;
               sdi_q   <= sr_q[23];
               cnt_q   <= '0;
               bit_q   <= '0;
               state_q <= SHIFT;
            end
            SHIFT: begin
               if (cnt_q != DIV_M1) begin
                  cnt_q <= cnt_q + 16'd1;
               end else begin
                  cnt_q <= '0;
                  if (sclk_q) begin
                     sclk_q <= 1'b0;
                  end else if (bit_q == 5'd23) begin
                     sclk_q  <= 1'b1;
                     cs_q    <= 1'b1;
                     sdi_q   <= 1'b0;
                     done_q  <= 1'b1;
                     gcnt_q  <= '0;
                     state_q <= GAP;
                  end else begin
                     sclk_q <= 1'b1;
                     sr_q   <= {sr_q[22:0], 1'b0};
                     sdi_q  <= sr_q[22];
                     bit_q  <= bit_q + 5'd1;
                  end
               end
            end
            GAP: begin
               if (gcnt_q == GAP_M1) state_q <= IDLE;
               else                  gcnt_q  <= gcnt_q + 16'd1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign frameDone = done_q;
   assign overrun   = ovr_q;
   assign dacCs_n   = cs_q;
   assign dacSclk   = sclk_q;
   assign dacSdi    = sdi_q;

endmodule

// File: tb/tb_dac_spi_driver.sv
// tb_dac_spi_driver: self-checking bench for dac_spi_driver.
// Monitor decodes SPI frames; expected frames come from a scoreboard queue.
module tb_dac_spi_driver;

   localparam int CLK_DIV = 2;
   localparam int CS_GAP  = 4;
`ifdef DAC_OFFSET_BINARY_EN
   localparam logic [15:0] TB_FLIP = 16'h8000;
`else
   localparam logic [15:0] TB_FLIP = 16'h0000;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        readyToOutput;
   logic        sampleStrobe;
   logic [15:0] dataIn;
   logic        busy;
   logic        frameDone;
   logic        overrun;
   logic        dacCs_n;
   logic        dacSclk;
   logic        dacSdi;

   dac_spi_driver #(
      .CLK_DIV (CLK_DIV),
      .CMD_WORD(8'h30),
      .CS_GAP  (CS_GAP)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .readyToOutput(readyToOutput),
      .sampleStrobe (sampleStrobe),
      .dataIn       (dataIn),
      .busy         (busy),
      .frameDone    (frameDone),
      .overrun      (overrun),
      .dacCs_n      (dacCs_n),
      .dacSclk      (dacSclk),
      .dacSdi       (dacSdi)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [23:0] frame;
      int          nb;
      int          cl;
      logic        fd;
      int          tf;
      int          tr;
   } obs_t;

   typedef struct {
      logic [15:0] din;
      logic [23:0] exp;
   } vec_t;

   obs_t        obs_a[64];
   int          obs_n  = 0;
   int          fd_cnt = 0;
   logic [23:0] sh;
   int          nb, cl, tf;
   logic        pcs, psclk;

   // Frame monitor: samples SDI on each SCLK fall while CS is low.
   always @(negedge clock) begin
      if (frameDone) fd_cnt = fd_cnt + 1;
      if (reset) begin
         sh = '0; nb = 0; cl = 0; pcs = 1'b1; psclk = 1'b1;
      end else begin
         if (pcs && !dacCs_n) tf = cyc;
         if (!dacCs_n) begin
            cl = cl + 1;
            if (psclk && !dacSclk) begin
               sh = {sh[22:0], dacSdi};
               nb = nb + 1;
            end
         end
         if (!pcs && dacCs_n && obs_n < 64) begin
            obs_a[obs_n] = '{sh, nb, cl, frameDone, tf, cyc};
            obs_n = obs_n + 1;
            sh = '0; nb = 0; cl = 0;
         end
         pcs   = dacCs_n;
         psclk = dacSclk;
      end
   end

   int          n_tests = 0;
   int          n_fail  = 0;
   int          rd      = 0;
   int          t_strobe;
   logic [23:0] exp_q[$];
   vec_t        vecs[6];

   task automatic check(input string name, input longint act,
                        input longint req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [23:0] fr(input logic [15:0] d);
      return {8'h30, d ^ TB_FLIP};
   endfunction

   task automatic strobe(input logic [15:0] d);
      @(negedge clock);
      dataIn       = d;
      sampleStrobe = 1'b1;
      t_strobe     = cyc;
      @(negedge clock);
      sampleStrobe = 1'b0;
      dataIn       = 16'($urandom);
   endtask

   task automatic wait_obs(input int n);
      int k = 0;
      while (obs_n - rd < n && k < 3000) begin
         @(negedge clock);
         k++;
      end
      check("frame arrival", (obs_n - rd >= n) ? 1 : 0, 1);
   endtask

   task automatic wait_cs(input logic lvl);
      int k = 0;
      while (dacCs_n !== lvl && k < 500) begin
         @(negedge clock);
         k++;
      end
      check("cs level reached", dacCs_n, lvl);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 3000) begin
         @(negedge clock);
         k++;
      end
      check("returns idle", busy, 0);
      repeat (2) @(negedge clock);
   endtask

   task automatic check_frame(input string name, output obs_t o);
      logic [23:0] e;
      if (rd >= obs_n || exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: frame or expectation missing", name);
         o = '{24'h0, 0, 0, 1'b0, 0, 0};
         return;
      end
      o  = obs_a[rd];
      rd = rd + 1;
      e  = exp_q.pop_front();
      check({name, " data"},  o.frame, e);
      check({name, " sclk falls"}, o.nb, 24);
      check({name, " cs low"}, o.cl, 48 * CLK_DIV);
      check({name, " frameDone"}, o.fd, 1);
   endtask

   initial begin
      obs_t o, o2;
      int   n, fdb, falls, bad, k;
      logic ps;

      vecs[0] = '{16'hA5C3, fr(16'hA5C3)};
      vecs[1] = '{16'h0000, fr(16'h0000)};
      vecs[2] = '{16'hFFFF, fr(16'hFFFF)};
      vecs[3] = '{16'h7FFF, fr(16'h7FFF)};
      vecs[4] = '{16'h8001, fr(16'h8001)};
      vecs[5] = '{16'h1234, fr(16'h1234)};

      reset         = 1'b1;
      readyToOutput = 1'b1;
      sampleStrobe  = 1'b0;
      dataIn        = '0;
      repeat (3) @(negedge clock);
      check("rst busy", busy, 0);
      check("rst frameDone", frameDone, 0);
      check("rst overrun", overrun, 0);
      check("rst cs_n", dacCs_n, 1);
      check("rst sclk", dacSclk, 1);
      check("rst sdi", dacSdi, 0);

`ifdef DAC_OFFSET_BINARY_EN
      exp_q.push_back(24'h308000);
`endif
      reset = 1'b0;
`ifdef DAC_OFFSET_BINARY_EN
      wait_obs(1);
      check_frame("park", o);
      wait_idle();
`endif

      for (int i = 0; i < 6; i++) begin
         fdb = fd_cnt;
         strobe(vecs[i].din);
         exp_q.push_back(vecs[i].exp);
         wait_cs(1'b0);
         wait_cs(1'b1);
         n = 0;
         while (busy && n < 50) begin
            @(negedge clock);
            n++;
         end
         check("busy tail", n, CS_GAP + 1);
         wait_obs(1);
         check_frame("vec", o);
         check("latency", o.tf - t_strobe, 2);
         check("single frameDone", fd_cnt - fdb, 1);
         wait_idle();
      end

      strobe(16'h1111);
      exp_q.push_back(fr(16'h1111));
      repeat (30) @(negedge clock);
      strobe(16'h2222);
      exp_q.push_back(fr(16'h2222));
      wait_obs(2);
      check_frame("b2b first", o);
      check_frame("b2b second", o2);
      check("b2b gap", o2.tf - o.tr, CS_GAP + 2);
      check("b2b overrun", overrun, 0);
      wait_idle();

      strobe(16'h1111);
      exp_q.push_back(fr(16'h1111));
      repeat (20) @(negedge clock);
      strobe(16'h2222);
      repeat (10) @(negedge clock);
      strobe(16'h3333);
      exp_q.push_back(fr(16'h3333));
      check("overrun set", overrun, 1);
      wait_obs(2);
      check_frame("ovr first", o);
      check_frame("ovr second", o2);
      check("overrun sticky", overrun, 1);
      readyToOutput = 1'b0;
      @(negedge clock);
      readyToOutput = 1'b1;
      check("overrun cleared", overrun, 0);
      wait_idle();

      fdb = fd_cnt;
      strobe(16'h4444);
      falls = 0;
      k     = 0;
      ps    = dacSclk;
      while (falls < 10 && k < 1000) begin
         @(negedge clock);
         if (!dacCs_n && ps && !dacSclk) falls++;
         ps = dacSclk;
         k++;
      end
      check("falls before reset", falls, 10);
      reset = 1'b1;
      @(negedge clock);
      check("abort cs_n", dacCs_n, 1);
      check("abort sclk", dacSclk, 1);
      check("abort sdi", dacSdi, 0);
      check("abort busy", busy, 0);
      @(negedge clock);
      check("abort no frameDone", fd_cnt - fdb, 0);
`ifdef DAC_OFFSET_BINARY_EN
      exp_q.push_back(24'h308000);
`endif
      reset = 1'b0;
      strobe(16'h5555);
      exp_q.push_back(fr(16'h5555));
      wait_obs(exp_q.size());
      while (exp_q.size() > 0) check_frame("post reset", o);
      wait_idle();

      readyToOutput = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         strobe(16'hFFFF);
         repeat (3) begin
            @(negedge clock);
            if (!dacCs_n || busy) bad++;
         end
      end
      check("disabled stays idle", bad, 0);
      readyToOutput = 1'b1;
      strobe(16'h6666);
      exp_q.push_back(fr(16'h6666));
      repeat (20) @(negedge clock);
      strobe(16'h7777);
      @(negedge clock);
      readyToOutput = 1'b0;
      @(negedge clock);
      readyToOutput = 1'b1;
      wait_obs(1);
      check_frame("disable mid", o);
      repeat (40) @(negedge clock);
      check("pending discarded", obs_n - rd, 0);
      check("idle after discard", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
